// File: rtl/truth_table_scorer.sv
// ---------------------------------------------------------------------------
// truth_table_scorer
//
// Fitness evaluator for evolved gate-level boolean circuits. Walks every one
// of the 2**N_IN input vectors into the candidate circuit. Each vector is held
// for SETTLE_CYCLES clocks so the candidate's gate chain can settle. The
// candidate outputs are then sampled once and compared bit-by-bit with a
// target truth table. The score is the total number of matching output bits
// across the whole sweep.
//
// Optional feature macro: FIRST_FAIL_CAPTURE_EN
//   When defined, the block also records the first vector that showed any
//   mismatching output bit. This adds the o_fail_seen and o_fail_vec ports.
//
// Ports
//   i_clk        sole clock, rising edge
//   i_reset      synchronous, active-high reset
//   i_start      begin a sweep (honoured only while idle)
//   i_abort      cancel a running sweep, no done pulse
//   i_target     expected outputs, bit [v*N_OUT+k] = output k for vector v
//   o_dut_in     input vector driven into the candidate circuit
//   i_dut_out    candidate circuit outputs
//   o_busy       sweep in progress
//   o_done       one-cycle pulse at end of sweep
//   o_score      matching output bits over the full sweep
//   o_perfect    every output bit matched (valid with/after o_done)
//   o_fail_seen  (FIRST_FAIL_CAPTURE_EN) a mismatch has been seen this sweep
//   o_fail_vec   (FIRST_FAIL_CAPTURE_EN) vector of the first mismatch
// ---------------------------------------------------------------------------
module truth_table_scorer #(
  parameter int N_IN          = 4,
  parameter int N_OUT         = 4,
  parameter int SETTLE_CYCLES = 2,
  localparam int SCORE_W      = $clog2(N_OUT * (2 ** N_IN) + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic [N_OUT*(2**N_IN)-1:0]  i_target,
  output logic [N_IN-1:0]             o_dut_in,
  input  logic [N_OUT-1:0]            i_dut_out,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [SCORE_W-1:0]          o_score,
  output logic                        o_perfect
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic                        o_fail_seen,
  output logic [N_IN-1:0]             o_fail_vec
`endif
);

  localparam int NUM_VEC   = 2 ** N_IN;
  localparam int TGT_W     = N_OUT * NUM_VEC;
  localparam int CNT_W     = $clog2(SETTLE_CYCLES + 1);
  localparam int POP_W     = $clog2(N_OUT + 1);
  localparam int MAX_SCORE = TGT_W;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                w_accept;
  logic                w_abort;
  logic                w_lastVec;
  logic                w_settleDone;
  logic [TGT_W-1:0]    r_tgt;
  logic [N_IN:0]       r_vec;
  logic [CNT_W-1:0]    r_settleCnt;
  logic [SCORE_W-1:0]  r_score;
  logic                r_perfect;
  logic [N_OUT-1:0]    w_slice;
  logic [N_OUT-1:0]    w_match;
  logic [POP_W-1:0]    w_pop;
  logic [SCORE_W-1:0]  w_scoreNext;
  logic                w_anyMiss;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic                r_failSeen;
  logic [N_IN-1:0]     r_failVec;
`endif

  // The vector counter carries one spare bit, so it never wraps before the
  // last vector has been sampled.
  assign w_lastVec    = (r_vec == (N_IN + 1)'(NUM_VEC - 1));
  assign w_settleDone = (r_settleCnt == CNT_W'(SETTLE_CYCLES - 1));
  // Abort only matters once a sweep is running; while idle it is ignored.
  assign w_abort      = i_abort && (r_state != IDLE);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state and status decode. If abort and start arrive together while
  // idle, abort wins and the start is dropped.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_abort) begin
          w_accept    = 1'b1;
          w_nextState = SETTLE;
        end
      end
      SETTLE: begin
        o_busy = 1'b1;
        if (i_abort)           w_nextState = IDLE;
        else if (w_settleDone) w_nextState = SAMPLE;
      end
      SAMPLE: begin
        o_busy = 1'b1;
        if (i_abort)        w_nextState = IDLE;
        else if (w_lastVec) w_nextState = DONE;
        else                w_nextState = SETTLE;
      end
      DONE: begin
        o_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Compare the sampled outputs with this vector's slice of the latched
  // target, then count the bits that agree.
  always_comb begin
    w_slice   = r_tgt[int'(r_vec) * N_OUT +: N_OUT];
    w_match   = ~(i_dut_out ^ w_slice);
    w_anyMiss = ~&w_match;
    w_pop     = '0;
    for (int k = 0; k < N_OUT; k++) begin
      w_pop = w_pop + POP_W'(w_match[k]);
    end
    w_scoreNext = r_score + SCORE_W'(w_pop);
  end

  // Sweep datapath: target snapshot, vector/settle counters and the score
  // accumulator. The perfect flag is settled on the final sample, so it is
  // already valid in the cycle that done is high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tgt       <= '0;
      r_vec       <= '0;
      r_settleCnt <= '0;
      r_score     <= '0;
      r_perfect   <= 1'b0;
    end else if (w_abort) begin
      r_vec       <= '0;
      r_settleCnt <= '0;
      r_score     <= '0;
      r_perfect   <= 1'b0;
    end else if (w_accept) begin
      r_tgt       <= i_target;
      r_vec       <= '0;
      r_settleCnt <= '0;
      r_score     <= '0;
      r_perfect   <= 1'b0;
    end else begin
      case (r_state)
        SETTLE: r_settleCnt <= r_settleCnt + 1'b1;
        SAMPLE: begin
          r_score <= w_scoreNext;
          if (w_lastVec) begin
            r_perfect <= (w_scoreNext == SCORE_W'(MAX_SCORE));
          end else begin
            r_vec       <= r_vec + 1'b1;
            r_settleCnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  // The first mismatching vector is kept until the next accepted start, so
  // the controller can read it after done.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_failSeen <= 1'b0;
      r_failVec  <= '0;
    end else if (w_accept) begin
      r_failSeen <= 1'b0;
      r_failVec  <= '0;
    end else if (!w_abort && r_state == SAMPLE && w_anyMiss && !r_failSeen) begin
      r_failSeen <= 1'b1;
      r_failVec  <= r_vec[N_IN-1:0];
    end
  end

  assign o_fail_seen = r_failSeen;
  assign o_fail_vec  = r_failVec;
`else
  // Without the capture feature the mismatch flag has no consumer.
  logic w_unusedMiss;
  assign w_unusedMiss = w_anyMiss;
`endif

  assign o_dut_in  = r_vec[N_IN-1:0];
  assign o_score   = r_score;
  assign o_perfect = r_perfect;

endmodule

// File: tb/tb_truth_table_scorer.sv
// ---------------------------------------------------------------------------
// tb_truth_table_scorer
//
// Directed bench for truth_table_scorer at the default parameters
// (N_IN=4, N_OUT=4, SETTLE_CYCLES=2). The candidate circuit is modelled
// either as a straight loopback (dut_out = dut_in) or as a loopback delayed
// by two clocks. Expected values are computed by hand for each step.
//
// Cycle numbering: the cycle that follows clock edge n is called cycle n+1.
// A start accepted at edge T therefore gives done in cycle T+49, which is
// observed while the edge counter reads T+48.
// ---------------------------------------------------------------------------
module tb_truth_table_scorer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [63:0] target;
  logic [3:0]  dutIn;
  logic [3:0]  dutOut;
  logic        busy;
  logic        done;
  logic [6:0]  score;
  logic        perfect;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic        failSeen;
  logic [3:0]  failVec;
`endif

  int errors    = 0;
  int checks    = 0;
  int cycleCnt  = 0;
  int doneCount = 0;
  int expDone   = 0;
  int mode      = 0;
  int tStart;
  int lat;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [63:0] flipped;

  truth_table_scorer dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_abort    (abort),
    .i_target   (target),
    .o_dut_in   (dutIn),
    .i_dut_out  (dutOut),
    .o_busy     (busy),
    .o_done     (done),
    .o_score    (score),
    .o_perfect  (perfect)
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    .o_fail_seen(failSeen),
    .o_fail_vec (failVec)
`endif
  );

  always #5 clk = ~clk;

  // Edge counter used to measure start-to-done latency.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Candidate circuit model: mode 0 is a plain loopback, mode 1 delays the
  // loopback by two clocks.
  always @(posedge clk) begin
    d1 <= dutIn;
    d2 <= d1;
  end
  assign dutOut = (mode == 1) ? d2 : dutIn;

  // Tally done pulses away from the active edge.
  always @(negedge clk) if (done === 1'b1) doneCount++;

  function automatic logic [63:0] identityTable();
    logic [63:0] t;
    for (int v = 0; v < 16; v++) t[v*4 +: 4] = 4'(v);
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive start/abort for exactly one edge. Returns the edge count at that
  // edge, and leaves the bench 1 ns past it.
  task automatic applyStimulus(input logic s, input logic a, output int edgeNum);
    @(negedge clk);
    start = s;
    abort = a;
    @(posedge clk);
    #1;
    edgeNum = cycleCnt;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Bounded wait for done. Returns the latency in cycles from the accepting
  // edge, or -1 on timeout.
  task automatic waitDone(input int t0, output int latency);
    latency = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        latency = cycleCnt - t0 + 1;
        break;
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    target = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy",    32'(busy),    0);
    checkOutput("reset_done",    32'(done),    0);
    checkOutput("reset_score",   32'(score),   0);
    checkOutput("reset_perfect", 32'(perfect), 0);
    checkOutput("reset_dutin",   32'(dutIn),   0);
    @(negedge clk);
    reset = 1'b0;

    // Loopback against the identity table: a perfect score.
    $display("[TB] step 1: loopback, identity target");
    mode   = 0;
    target = identityTable();
    applyStimulus(1'b1, 1'b0, tStart);
    checkOutput("t1_busy_after_start", 32'(busy), 1);
    waitDone(tStart, lat);
    expDone++;
    checkOutput("t1_latency", 32'(lat), 49);
    checkOutput("t1_score",   32'(score), 64);
    checkOutput("t1_perfect", 32'(perfect), 1);
    checkOutput("t1_busy_at_done", 32'(busy), 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    checkOutput("t1_fail_seen", 32'(failSeen), 0);
`endif
    @(negedge clk);
    checkOutput("t1_done_one_cycle", 32'(done), 0);
    repeat (3) @(negedge clk);
    checkOutput("t1_score_hold",   32'(score), 64);
    checkOutput("t1_perfect_hold", 32'(perfect), 1);
    checkOutput("t1_done_count",   32'(doneCount), 32'(expDone));

    // Inverted table. The table is swapped back to identity mid-sweep, and
    // that change must be ignored, so the score stays zero.
    $display("[TB] step 2: loopback, inverted target");
    target = ~identityTable();
    applyStimulus(1'b1, 1'b0, tStart);
    checkOutput("t2_start_clears_perfect", 32'(perfect), 0);
    target = identityTable();
    waitDone(tStart, lat);
    expDone++;
    checkOutput("t2_latency", 32'(lat), 49);
    checkOutput("t2_score",   32'(score), 0);
    checkOutput("t2_perfect", 32'(perfect), 0);

    // A single flipped bit (vector 5, output 2) costs exactly one point.
    $display("[TB] step 3: one flipped target bit");
    flipped     = identityTable();
    flipped[22] = ~flipped[22];
    target      = flipped;
    applyStimulus(1'b1, 1'b0, tStart);
    waitDone(tStart, lat);
    expDone++;
    checkOutput("t3_score",   32'(score), 63);
    checkOutput("t3_perfect", 32'(perfect), 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    checkOutput("t3_fail_seen", 32'(failSeen), 1);
    checkOutput("t3_fail_vec",  32'(failVec), 5);
`endif

    // A two-clock delayed candidate still settles inside two settle cycles.
    $display("[TB] step 4: two-clock delayed candidate");
    mode   = 1;
    target = identityTable();
    applyStimulus(1'b1, 1'b0, tStart);
    waitDone(tStart, lat);
    expDone++;
    checkOutput("t4_score",   32'(score), 64);
    checkOutput("t4_perfect", 32'(perfect), 1);
    mode = 0;

    // A start pulse at cycle 10 is ignored. At that point vectors 0..2 have
    // been sampled (score 12), and vector 3 is being driven.
    $display("[TB] step 5: start ignored mid-sweep, then abort");
    applyStimulus(1'b1, 1'b0, tStart);
    repeat (9) @(posedge clk);
    applyStimulus(1'b1, 1'b0, lat);
    checkOutput("t5_edge10",        32'(lat - tStart), 10);
    checkOutput("t5_midsweep_vec",  32'(dutIn), 3);
    checkOutput("t5_midsweep_score", 32'(score), 12);
    checkOutput("t5_still_busy",    32'(busy), 1);
    waitDone(tStart, lat);
    expDone++;
    checkOutput("t5_latency", 32'(lat), 49);
    @(negedge clk);
    checkOutput("t5_single_done", 32'(doneCount), 32'(expDone));

    // Abort at cycle 20: the sweep stops at once and produces no done pulse.
    applyStimulus(1'b1, 1'b0, tStart);
    repeat (19) @(posedge clk);
    applyStimulus(1'b0, 1'b1, lat);
    checkOutput("t5_abort_busy",  32'(busy), 0);
    checkOutput("t5_abort_score", 32'(score), 0);
    checkOutput("t5_abort_dutin", 32'(dutIn), 0);
    repeat (60) @(negedge clk);
    checkOutput("t5_abort_no_done", 32'(doneCount), 32'(expDone));

    // With start and abort together in idle, abort wins.
    applyStimulus(1'b1, 1'b1, tStart);
    checkOutput("t5_start_abort_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    checkOutput("t5_start_abort_idle", 32'(busy), 0);

    // A reset mid-sweep returns every output to its reset value.
    $display("[TB] step 6: reset mid-sweep");
    applyStimulus(1'b1, 1'b0, tStart);
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_reset_busy",    32'(busy),    0);
    checkOutput("t6_reset_done",    32'(done),    0);
    checkOutput("t6_reset_score",   32'(score),   0);
    checkOutput("t6_reset_perfect", 32'(perfect), 0);
    checkOutput("t6_reset_dutin",   32'(dutIn),   0);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    checkOutput("t6_reset_no_done", 32'(doneCount), 32'(expDone));
    applyStimulus(1'b1, 1'b0, tStart);
    waitDone(tStart, lat);
    expDone++;
    checkOutput("t6_latency", 32'(lat), 49);
    checkOutput("t6_score",   32'(score), 64);
    checkOutput("t6_perfect", 32'(perfect), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
